// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern and match counter.
// Define SEQDET_WRAP_EN for a wrapping counter (sat on wrap); default build saturates.
module seq_det_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               d,
    input  logic               overlap,
    input  logic               pat_ld,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clr,
    output logic               q,
    output logic [CNT_W-1:0]   num,
    output logic               sat
);
    localparam int            FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d, pat_q, pat_d, h_next;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   num_q, num_d, num_inc;
    logic               q_q, q_d, sat_q, sat_d, match;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        num_d   = num_q;
        sat_d   = sat_q;
        q_d     = 1'b0;
        match   = 1'b0;
        h_next  = {hist_q[PAT_LEN-2:0], d};
        num_inc = num_q + 1'b1;

        if (pat_ld) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            // fill_q >= PAT_LEN-1 means h_next holds PAT_LEN real samples
            match = (fill_q >= FULL - 1'b1) && (h_next == pat_q);
            q_d   = match;
            if (match && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = h_next;
                fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
            end
        end

        // A match coinciding with clr still counts as the first event after the clear
        if (clr) begin
            num_d = match ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (match) begin
`ifdef SEQDET_WRAP_EN
            num_d = num_inc;
            if (num_q == '1) sat_d = 1'b1;
`else
            if (num_q != '1) begin
                num_d = num_inc;
                if (num_inc == '1) sat_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            num_q  <= '0;
            sat_q  <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            num_q  <= num_d;
            sat_q  <= sat_d;
            q_q    <= q_d;
        end
    end

    assign q   = q_q;
    assign num = num_q;
    assign sat = sat_q;
endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed tables, corner sequences, and random stream vs a queue model.
module tb_seq_det_param;
    localparam int P = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst, en, d, overlap, pat_ld, clr, q, sat;
    logic [P-1:0] pat_in;
    logic [W-1:0] num;
    logic pat_ld6, q6, sat6;
    logic [5:0] pat_in6;
    logic [3:0] num6;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic   mbits[$];
    logic [P-1:0] mpat;
    int     mcnt;
    logic   mq;

    always #5 clk = ~clk;

    seq_det_param dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .overlap(overlap), .pat_ld(pat_ld),
        .pat_in(pat_in), .clr(clr), .q(q), .num(num), .sat(sat)
    );

    seq_det_param #(.PAT_LEN(6), .PATTERN(6'b000001), .CNT_W(4)) dut6 (
        .clk(clk), .rst(rst), .en(en), .d(d), .overlap(overlap), .pat_ld(pat_ld6),
        .pat_in(pat_in6), .clr(clr), .q(q6), .num(num6), .sat(sat6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdl(input logic r, ld, e, dd, ov, cl, input logic [P-1:0] pin);
        logic m = 1'b0;
        logic [P-1:0] last;
        if (r) begin
            mbits.delete(); mpat = 4'b1001; mcnt = 0; mq = 1'b0;
            return;
        end
        mq = 1'b0;
        if (ld) begin
            mpat = pin;
            mbits.delete();
        end else if (e) begin
            mbits.push_back(dd);
            if (mbits.size() > P) void'(mbits.pop_front());
            if (mbits.size() == P) begin
                for (int i = 0; i < P; i++) last[P-1-i] = mbits[i];
                m = (last == mpat);
            end
            if (m) begin
                mq = 1'b1;
                if (!ov) mbits.delete();
            end
        end
        if (cl) mcnt = m ? 1 : 0;
        else if (m) mcnt++;
    endtask

    function automatic int exp_num();
`ifdef SEQDET_WRAP_EN
        return mcnt % (1 << W);
`else
        return (mcnt > (1 << W) - 1) ? (1 << W) - 1 : mcnt;
`endif
    endfunction

    function automatic logic exp_sat();
`ifdef SEQDET_WRAP_EN
        return mcnt >= (1 << W);
`else
        return mcnt >= (1 << W) - 1;
`endif
    endfunction

    task automatic drive(input logic r, ld, e, dd, ov, cl, input logic [P-1:0] pin);
        rst = r; pat_ld = ld; en = e; d = dd; overlap = ov; clr = cl; pat_in = pin;
        mdl(r, ld, e, dd, ov, cl, pin);
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic dd, input logic ov);
        drive(1'b0, 1'b0, 1'b1, dd, ov, 1'b0, '0);
    endtask

    task automatic do_rst();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    typedef struct {
        logic d;
        logic ov;
        logic exp_q;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [18:0] s1;
        logic [15:0] s3;
        logic [8:0]  s6;
        logic [3:0]  s_rst;
        logic [P-1:0] rp;
        logic ov_r;

        pat_ld6 = 1'b0; pat_in6 = '0;
        s1 = 19'b1010010011000100101;
        s3 = 16'b1001001001001001;
        s6 = 9'b110110110;

        do_rst();
        chk("reset_q", q, 0);
        chk("reset_num", num, 0);
        chk("reset_sat", sat, 0);

        // Test-plan stream, overlap then non-overlap
        for (int ov = 1; ov >= 0; ov--) begin
            tbl.delete();
            for (int i = 0; i < 19; i++) begin
                vec_t v;
                v.d     = s1[18-i];
                v.ov    = ov[0];
                v.exp_q = (i == 5) || (i == 16) || (ov == 1 && i == 8);
                tbl.push_back(v);
            end
            do_rst();
            foreach (tbl[i]) begin
                bit_in(tbl[i].d, tbl[i].ov);
                chk($sformatf("s1_ov%0d_q[%0d]", ov, i + 1), q, tbl[i].exp_q);
            end
            if (ov == 1) begin
                chk("s1_ov1_num", num, 3);
`ifdef SEQDET_WRAP_EN
                chk("s1_ov1_sat", sat, 0);
`else
                chk("s1_ov1_sat", sat, 1);
`endif
            end else begin
                chk("s1_ov0_num", num, 2);
                chk("s1_ov0_sat", sat, 0);
            end
        end

        // Five overlapping matches: saturate or wrap
        do_rst();
        for (int i = 0; i < 16; i++) bit_in(s3[15-i], 1'b1);
`ifdef SEQDET_WRAP_EN
        chk("five_num", num, 1);
`else
        chk("five_num", num, 3);
`endif
        chk("five_sat", sat, 1);

        // clr on the same edge as a match
        do_rst();
        for (int i = 0; i < 15; i++) bit_in(s3[15-i], 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0);
        chk("clr_match_q", q, 1);
        chk("clr_match_num", num, 1);
        chk("clr_match_sat", sat, 0);

        // en gap holds partial history
        do_rst();
        bit_in(1, 1); bit_in(0, 1); bit_in(0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
            chk($sformatf("idle_q[%0d]", i), q, 0);
        end
        bit_in(1, 1);
        chk("idle_resume_q", q, 1);
        chk("idle_resume_num", num, 1);

        // rst mid-stream discards partial match
        do_rst();
        bit_in(1, 1); bit_in(0, 1); bit_in(0, 1);
        do_rst();
        chk("midrst_q", q, 0);
        s_rst = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            bit_in(s_rst[3-i], 1'b1);
            chk($sformatf("midrst_q[%0d]", i + 1), q, (i == 3));
        end

        // Periodicity-1 pattern gives back-to-back pulses
        do_rst();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111);
        chk("ld_q", q, 0);
        for (int i = 0; i < 6; i++) begin
            bit_in(1, 1);
            chk($sformatf("ones_q[%0d]", i + 1), q, (i >= 3));
        end

        // PAT_LEN=6 instance with runtime-loaded pattern
        do_rst();
        pat_ld6 = 1'b1; pat_in6 = 6'b110110;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        pat_ld6 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bit_in(s6[8-i], 1'b1);
            chk($sformatf("p6_q[%0d]", i + 1), q6, (i == 5 || i == 8));
        end
        chk("p6_num", num6, 2);

        // Random stream against the queue model
        do_rst();
        ov_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) ov_r = ~ov_r;
            rp = P'($urandom);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) != 0, 1'($urandom), ov_r,
                  $urandom_range(0, 79) == 0, rp);
            chk("rnd_q", q, mq);
            chk("rnd_num", num, exp_num());
            chk("rnd_sat", sat, exp_sat());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
